dma_channel_arbiter: RTL and testbench

// - Four-channel request arbiter/scheduler for the 8237-style DMA: qualifies DREQ/software requests,

---
 rtl/dma_arb_pkg.sv | 18 +
 rtl/dma_prio_encoder.sv | 34 +++
 rtl/dma_channel_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the four-channel DMA request arbiter.
package dma_arb_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_SVC  = 2'd2
  } arb_state_e;

  typedef logic [1:0] ch_idx_t;

  function automatic logic [3:0] ch_onehot(input ch_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational priority encoder: fixed (ch0 highest) or rotating from ptr with 3->0 wrap.
module dma_prio_encoder
  import dma_arb_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    ptr,
  input  logic       rotate,
  output logic [3:0] grant,
  output ch_idx_t    idx,
  output logic       any
);

  ch_idx_t start_s;
  ch_idx_t cand_s;
  logic    hit_s;

  // Walk the channels from the start point; the first requester found wins
  always_comb begin
    grant   = 4'b0000;
    idx     = 2'd0;
    any     = 1'b0;
    cand_s  = 2'd0;
    hit_s   = 1'b0;
    start_s = rotate ? ptr : 2'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = start_s + ch_idx_t'(k);
      hit_s  = !any && req[cand_s];
      grant  = hit_s ? ch_onehot(cand_s) : grant;
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// 8237-style DMA channel arbiter: DREQ synchronisation and qualification, winner selection,
// HRQ/HLDA handshake, DACK generation and terminal-count status.
module dma_channel_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       dreq_sense_low,
  input  logic       dack_sense_high,
  input  logic       ctrl_disable,
  input  logic       rotate_prio,
  input  logic [3:0] mask,
  input  logic [3:0] sw_req,
  input  logic       HLDA,
  input  logic       dack_en,
  input  logic       svc_done,
  input  logic       tc_in,
  input  logic       status_rd,
  output logic       hrq,
  output logic [3:0] valid_dreq,
  output logic [3:0] DACK,
  output logic [1:0] cur_ch,
  output logic [3:0] req_status,
  output logic [3:0] tc_status,
  output logic [3:0] sw_req_clr
);
  import dma_arb_pkg::*;

  logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0] req_eff_s;
  logic [3:0]        grant_s;
  ch_idx_t           win_idx_s;
  logic              any_s;

  arb_state_e        state_r;
  ch_idx_t           cur_ch_r;
  ch_idx_t           prio_ptr_r;
  logic              hrq_r;
  logic [3:0]        valid_r;
  logic [3:0]        tc_r;
  logic [3:0]        tc_next_s;
  logic [3:0]        req_status_r;
  logic [3:0]        sw_clr_r;
  logic [3:0]        dack_act_s;

  // DREQ synchroniser chain
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {NUM_CH{1'b0}};
    end else begin
      sync_r[0] <= DREQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Qualified requests; software requests bypass both mask and sense
  always_comb begin
    req_eff_s = {NUM_CH{1'b0}};
    if (!ctrl_disable) begin
      req_eff_s = ((sync_r[SYNC_STAGES-1] ^ {NUM_CH{dreq_sense_low}}) & ~mask) | sw_req;
    end else begin
      req_eff_s = {NUM_CH{1'b0}};
    end
  end

  dma_prio_encoder u_prio (
    .req    (req_eff_s),
    .ptr    (prio_ptr_r),
    .rotate (rotate_prio),
    .grant  (grant_s),
    .idx    (win_idx_s),
    .any    (any_s)
  );

  // A TC reported at completion beats a same-cycle status read for that bit
  always_comb begin
    tc_next_s = status_rd ? 4'b0000 : tc_r;
    if (state_r == ARB_SVC && HLDA && svc_done && tc_in) begin
      tc_next_s = tc_next_s | valid_r;
    end else begin
      tc_next_s = tc_next_s;
    end
  end

  // Arbitration FSM, rotation pointer and status registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= ARB_IDLE;
      cur_ch_r     <= 2'd0;
      prio_ptr_r   <= 2'd0;
      hrq_r        <= 1'b0;
      valid_r      <= 4'b0000;
      tc_r         <= 4'b0000;
      req_status_r <= 4'b0000;
      sw_clr_r     <= 4'b0000;
    end else begin
      req_status_r <= req_eff_s;
      tc_r         <= tc_next_s;
      sw_clr_r     <= 4'b0000;
      case (state_r)
        ARB_IDLE: begin
          if (any_s) begin
            cur_ch_r <= win_idx_s;
            valid_r  <= grant_s;
            hrq_r    <= 1'b1;
            state_r  <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (HLDA) begin
            state_r <= ARB_SVC;
          end else if (!req_eff_s[cur_ch_r]) begin
            hrq_r   <= 1'b0;
            valid_r <= 4'b0000;
            state_r <= ARB_IDLE;
          end
        end
        ARB_SVC: begin
          if (!HLDA) begin
            hrq_r   <= 1'b0;
            valid_r <= 4'b0000;
            state_r <= ARB_IDLE;
          end else if (svc_done) begin
            hrq_r   <= 1'b0;
            valid_r <= 4'b0000;
            state_r <= ARB_IDLE;
            if (rotate_prio) prio_ptr_r <= cur_ch_r + 2'd1;
            if (sw_req[cur_ch_r]) sw_clr_r <= valid_r;
          end
        end
        default: begin
          hrq_r   <= 1'b0;
          valid_r <= 4'b0000;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // DACK is asserted for the winner only inside the timing FSM's window
  always_comb begin
    dack_act_s = 4'b0000;
    if (state_r == ARB_SVC && dack_en) begin
      dack_act_s = valid_r;
    end else begin
      dack_act_s = 4'b0000;
    end
  end

  assign DACK       = dack_sense_high ? dack_act_s : ~dack_act_s;
  assign hrq        = hrq_r;
  assign valid_dreq = valid_r;
  assign cur_ch     = cur_ch_r;
  assign req_status = req_status_r;
  assign tc_status  = tc_r;
  assign sw_req_clr = sw_clr_r;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the arbiter.
module tb_dma_channel_arbiter;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, mask, sw_req;
  logic       dreq_sense_low, dack_sense_high, ctrl_disable, rotate_prio;
  logic       HLDA, dack_en, svc_done, tc_in, status_rd;
  logic       hrq;
  logic [3:0] valid_dreq, DACK, req_status, tc_status, sw_req_clr;
  logic [1:0] cur_ch;

  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.NUM_CH(4), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreq_sense_low(dreq_sense_low),
    .dack_sense_high(dack_sense_high), .ctrl_disable(ctrl_disable), .rotate_prio(rotate_prio),
    .mask(mask), .sw_req(sw_req), .HLDA(HLDA), .dack_en(dack_en), .svc_done(svc_done),
    .tc_in(tc_in), .status_rd(status_rd), .hrq(hrq), .valid_dreq(valid_dreq), .DACK(DACK),
    .cur_ch(cur_ch), .req_status(req_status), .tc_status(tc_status), .sw_req_clr(sw_req_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a channel is "held" while hrq is up, "serving" once HLDA was seen
  logic [3:0] hist[$];
  logic       m_hrq, m_serving;
  int         m_ch, m_ptr;
  logic [3:0] m_tc, m_rs, m_clr;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] model_req();
    logic [3:0] raw;
    logic [3:0] r;
    logic       active;
    raw = hist[SYNC-1];
    r   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      active = dreq_sense_low ? !raw[i] : raw[i];
      r[i]   = !ctrl_disable && ((active && !mask[i]) || sw_req[i]);
    end
    return r;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = rotate_prio ? (m_ptr + k) % 4 : k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hrq = 1'b0; m_serving = 1'b0; m_ch = 0; m_ptr = 0;
    m_tc = 4'b0000; m_rs = 4'b0000; m_clr = 4'b0000;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(4'b0000);
  endtask

  task automatic model_step();
    logic [3:0] r;
    logic [3:0] tcn;
    int         w;
    r     = model_req();
    tcn   = status_rd ? 4'b0000 : m_tc;
    m_clr = 4'b0000;
    if (!m_hrq) begin
      w = model_pick(r);
      if (w >= 0) begin
        m_ch = w; m_hrq = 1'b1; m_serving = 1'b0;
      end
    end else if (!m_serving) begin
      if (HLDA) m_serving = 1'b1;
      else if (!r[m_ch]) m_hrq = 1'b0;
    end else if (!HLDA) begin
      m_hrq = 1'b0; m_serving = 1'b0;
    end else if (svc_done) begin
      m_hrq = 1'b0; m_serving = 1'b0;
      if (rotate_prio) m_ptr = (m_ch + 1) % 4;
      if (tc_in) tcn[m_ch] = 1'b1;
      if (sw_req[m_ch]) m_clr[m_ch] = 1'b1;
    end
    m_tc = tcn;
    m_rs = r;
    hist.push_front(DREQ);
    void'(hist.pop_back());
  endtask

  task automatic compare_all();
    logic [3:0] one, act;
    one = m_hrq ? (4'b0001 << m_ch) : 4'b0000;
    act = (m_serving && dack_en) ? one : 4'b0000;
    check("hrq", 4'(hrq), 4'(m_hrq));
    check("valid_dreq", valid_dreq, one);
    check("cur_ch", 4'(cur_ch), 4'(m_ch));
    check("dack", DACK, dack_sense_high ? act : ~act);
    check("req_status", req_status, m_rs);
    check("tc_status", tc_status, m_tc);
    check("sw_req_clr", sw_req_clr, m_clr);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge
  task automatic tick();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_step();
    #1;
  endtask

  task automatic wait_hrq();
    int n;
    n = 0;
    while (!hrq && n < 20) begin
      tick();
      n++;
    end
    check("hrq_wait", 4'(hrq), 4'd1);
  endtask

  task automatic serve(input int exp_ch, input int hlda_delay, input logic tc, input logic rd);
    logic [3:0] one;
    one = 4'b0001 << exp_ch;
    wait_hrq();
    check("grant_ch", 4'(cur_ch), 4'(exp_ch));
    check("grant_onehot", valid_dreq, one);
    for (int i = 0; i < hlda_delay; i++) tick();
    HLDA = 1'b1;
    tick();
    dack_en = 1'b1;
    #1;
    check("dack_window", DACK, dack_sense_high ? one : ~one);
    tick();
    dack_en = 1'b0; svc_done = 1'b1; tc_in = tc; status_rd = rd;
    tick();
    svc_done = 1'b0; tc_in = 1'b0; status_rd = 1'b0; HLDA = 1'b0;
    check("hrq_release", 4'(hrq), 4'd0);
  endtask

  task automatic settle();
    ctrl_disable = 1'b1;
    repeat (3) tick();
    ctrl_disable = 1'b0;
  endtask

  initial begin
    DREQ = 4'b0000; mask = 4'b0000; sw_req = 4'b0000;
    dreq_sense_low = 1'b0; dack_sense_high = 1'b1; ctrl_disable = 1'b0; rotate_prio = 1'b0;
    HLDA = 1'b0; dack_en = 1'b0; svc_done = 1'b0; tc_in = 1'b0; status_rd = 1'b0;
    RESET = 1'b1;
    model_reset();
    #1;
    check("rst_hrq", 4'(hrq), 4'd0);
    check("rst_valid", valid_dreq, 4'b0000);
    check("rst_dack", DACK, 4'b0000);
    check("rst_tc", tc_status, 4'b0000);
    tick(); tick();
    RESET = 1'b0;

    // Fixed priority: ch1 beats ch3, HLDA three cycles after the grant
    DREQ = 4'b1010;
    serve(1, 3, 1'b0, 1'b0);

    // Rotating priority with every channel requesting
    DREQ = 4'b1111; rotate_prio = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) serve(i % 4, 0, 1'b0, 1'b0);

    // Active-low sense with ch0 masked, then a software request for ch0
    rotate_prio = 1'b0; dreq_sense_low = 1'b1; mask = 4'b0001; DREQ = 4'b1100;
    settle();
    serve(1, 0, 1'b0, 1'b0);
    sw_req = 4'b0001;
    serve(0, 0, 1'b0, 1'b0);
    check("sw_clr_pulse", sw_req_clr, 4'b0001);
    sw_req = 4'b0000;

    // Terminal count flags and a status read racing a new TC
    mask = 4'b1111; dreq_sense_low = 1'b0; DREQ = 4'b0000; sw_req = 4'b0100;
    settle();
    serve(2, 0, 1'b1, 1'b0);
    check("tc_ch2", tc_status, 4'b0100);
    sw_req = 4'b1000;
    serve(3, 0, 1'b1, 1'b1);
    check("tc_rd_race", tc_status, 4'b1000);
    sw_req = 4'b0000;

    // Request withdrawn before HLDA: visible after the synchroniser delay
    mask = 4'b0000; DREQ = 4'b0001;
    settle();
    wait_hrq();
    check("abort_ch", 4'(cur_ch), 4'd0);
    DREQ = 4'b0000;
    tick(); tick();
    check("abort_hold", 4'(hrq), 4'd1);
    tick();
    check("abort_drop", 4'(hrq), 4'd0);

    // HLDA lost during service leaves the rotation pointer at 1, so ch3 wins twice
    rotate_prio = 1'b1; DREQ = 4'b1001;
    settle();
    wait_hrq();
    check("hlda_abort_ch", 4'(cur_ch), 4'd3);
    HLDA = 1'b1; tick();
    HLDA = 1'b0; tick();
    check("hlda_abort_hrq", 4'(hrq), 4'd0);
    serve(3, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a service with active-low DACK
    dack_sense_high = 1'b0;
    wait_hrq();
    HLDA = 1'b1; tick();
    dack_en = 1'b1; #1;
    check("svc_dack_low", DACK, 4'b1110);
    RESET = 1'b1; #1;
    check("async_rst_dack", DACK, 4'b1111);
    check("async_rst_hrq", 4'(hrq), 4'd0);
    check("async_rst_tc", tc_status, 4'b0000);
    model_reset();
    tick(); tick();
    RESET = 1'b0; HLDA = 1'b0; dack_en = 1'b0; dack_sense_high = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      sw_req = sw_req & ~m_clr;
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) sw_req = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 39) == 0) rotate_prio = ~rotate_prio;
      if ($urandom_range(0, 59) == 0) dreq_sense_low = ~dreq_sense_low;
      if ($urandom_range(0, 29) == 0) dack_sense_high = ~dack_sense_high;
      ctrl_disable = ($urandom_range(0, 15) == 0);
      HLDA      = m_hrq ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      dack_en   = 1'($urandom_range(0, 1));
      svc_done  = ($urandom_range(0, 3) == 0);
      tc_in     = 1'($urandom_range(0, 1));
      status_rd = ($urandom_range(0, 7) == 0);
      RESET     = ($urandom_range(0, 499) == 0);
      if (RESET) model_reset();
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
